// File: rtl/y86_defs.sv
// Shared Y86-64 definitions: instruction codes, status codes, word width and
// the memory-access decode used by the memory stage.
package y86_defs;

    localparam int WORD_W = 64;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 4'd4;

    typedef enum logic {
        ST_RUN,
        ST_STOPPED
    } mem_state_e;

    typedef struct packed {
        logic rd;
        logic wr;
        logic addr_from_vala;
        logic wdata_from_valp;
    } mem_ctl_t;

    function automatic mem_ctl_t decode_access(input logic [3:0] icode);
        mem_ctl_t c;
        c = '0;
        case (icode)
            I_RMMOVQ: c.wr = 1'b1;
            I_PUSHQ:  c.wr = 1'b1;
            I_CALL:   begin c.wr = 1'b1; c.wdata_from_valp = 1'b1; end
            I_MRMOVQ: c.rd = 1'b1;
            I_RET:    begin c.rd = 1'b1; c.addr_from_vala = 1'b1; end
            I_POPQ:   begin c.rd = 1'b1; c.addr_from_vala = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    // Fetch faults outrank decode faults, which outrank data-memory faults.
    function automatic logic [2:0] pick_stat(input logic imem_err, input logic ivalid,
                                             input logic dmem_err, input logic is_halt);
        if (imem_err)     return S_ADR;
        else if (!ivalid) return S_INS;
        else if (dmem_err) return S_ADR;
        else if (is_halt) return S_HLT;
        else              return S_AOK;
    endfunction

endpackage

// File: rtl/dmem.sv
// Byte-addressed data RAM: one 64-bit little-endian write port and one
// combinational 64-bit little-endian read port. Contents are never reset.
module dmem #(
    parameter int DMEM_BYTES = 1024,
    parameter int AW         = 64
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [$clog2(DMEM_BYTES)-1:0] addr,
    input  logic [AW-1:0]                 wdata,
    output logic [AW-1:0]                 rdata
);
    localparam int AIW = $clog2(DMEM_BYTES);

    logic [7:0] mem [DMEM_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < AW / 8; i++) begin
                mem[addr + AIW'(i)] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < AW / 8; i++) begin
            rdata[8*i +: 8] = mem[addr + AIW'(i)];
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Y86-64 memory stage: data-memory access for one instruction per start pulse,
// registered valM/dmem_error/done, and the sticky processor status register.
module mem_stage
    import y86_defs::*;
#(
    parameter int DMEM_BYTES = 1024,
    parameter int AW         = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [3:0]    icode,
    input  logic          instr_valid,
    input  logic          imem_error,
    input  logic [AW-1:0] valE,
    input  logic [AW-1:0] valA,
    input  logic [AW-1:0] valP,
    output logic          done,
    output logic [AW-1:0] valM,
    output logic          dmem_error,
    output logic [2:0]    stat
);
    localparam int AIW = $clog2(DMEM_BYTES);
    localparam logic [AW-1:0] ADDR_MAX = AW'(DMEM_BYTES - 8);

    mem_state_e    state_q, state_d;
    logic          done_q, done_d;
    logic [AW-1:0] valm_q, valm_d;
    logic          derr_q, derr_d;
    logic [2:0]    stat_q, stat_d;

    mem_ctl_t      ctl;
    logic [AW-1:0] addr, wdata, rdata;
    logic          addr_err, running, mem_we;
    logic [2:0]    stat_calc;

    assign ctl       = decode_access(icode);
    assign addr      = ctl.addr_from_vala ? valA : valE;
    assign wdata     = ctl.wdata_from_valp ? valP : valA;
    // Unsigned compare also catches addresses that would wrap past 2^64.
    assign addr_err  = (ctl.rd | ctl.wr) && (addr > ADDR_MAX);
    assign stat_calc = pick_stat(imem_error, instr_valid, addr_err, icode == I_HALT);
    assign running   = (state_q == ST_RUN);
    // Gating on rst keeps a store launched on the reset edge from committing.
    assign mem_we    = start && running && ctl.wr && !addr_err && !rst;

    dmem #(
        .DMEM_BYTES(DMEM_BYTES),
        .AW        (AW)
    ) u_dmem (
        .clk  (clk),
        .we   (mem_we),
        .addr (addr[AIW-1:0]),
        .wdata(wdata),
        .rdata(rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (running && start && stat_calc != S_AOK) state_d = ST_STOPPED;
    end

    always_comb begin
        done_d = start;
        valm_d = valm_q;
        derr_d = derr_q;
        stat_d = stat_q;
        if (start) begin
            valm_d = (running && ctl.rd && !addr_err) ? rdata : '0;
            derr_d = running && addr_err;
            if (running) stat_d = stat_calc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
            valm_q <= '0;
            derr_q <= 1'b0;
            stat_q <= S_AOK;
        end else begin
            done_q <= done_d;
            valm_q <= valm_d;
            derr_q <= derr_d;
            stat_q <= stat_d;
        end
    end

    assign done       = done_q;
    assign valM       = valm_q;
    assign dmem_error = derr_q;
    assign stat       = stat_q;

endmodule
